// File: rtl/pe_skew_feeder_pkg.sv
// Shared definitions for the pe_8x8_cluster skew feeder: tile geometry,
// feed-step counter sizing, FSM state encoding and lane packing helper.
package pe_skew_feeder_pkg;

  localparam int DATA_W = 16;
  localparam int ROWS   = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;

  // One tile buffer holds every word of every row.
  localparam int WORDS  = ROWS * DEPTH;

  // Last feed step: the final row emits its terminating zero word here.
  localparam int T_LAST = ROWS - 1 + DEPTH;
  localparam int T_W    = $clog2(ROWS + DEPTH);

  // Width of the in-row word index; kept at least one bit wide.
  localparam int K_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [T_W-1:0]    step_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Least significant bit of lane r inside a packed ROWS*DATA_W bus.
  function automatic int lane_lsb(input int lane);
    return lane * DATA_W;
  endfunction

endpackage

// File: rtl/pe_skew_feeder_if.sv
// Control, buffer-write and cluster-feed signals of the skew feeder.
// master: the side that loads tiles and starts feeds; slave: the feeder.
interface pe_skew_feeder_if;
  import pe_skew_feeder_pkg::*;

  logic                     en;
  logic                     wr_en;
  logic                     wr_sel;
  logic [ADDR_W-1:0]        wr_addr;
  word_t                    wr_data;
  logic                     start;
  logic                     busy;
  logic [ROWS*DATA_W-1:0]   activations;
  logic [ROWS*DATA_W-1:0]   weights;
  logic [ROWS-1:0]          done;

  modport master (
    output en, wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, activations, weights, done
  );

  modport slave (
    input  en, wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, activations, weights, done
  );

endinterface

// File: rtl/pe_skew_feeder_lane.sv
// One feed lane of the skew feeder. Lane LANE starts LANE steps after lane 0,
// streams its DEPTH words, then emits a zero word and raises a sticky done.
module pe_skew_feeder_lane
  import pe_skew_feeder_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  step,
  input  step_t                 t,
  input  word_t [DEPTH-1:0]     row_act,
  input  word_t [DEPTH-1:0]     row_wgt,
  output word_t                 act,
  output word_t                 wgt,
  output logic                  done
);

  localparam step_t LANE_T  = step_t'(LANE);
  localparam step_t DEPTH_T = step_t'(DEPTH);

  logic [T_W:0]   diff;
  logic           in_row;
  step_t          k;
  logic [K_W-1:0] k_idx;
  logic           word_hit;
  logic           end_hit;

  // Decode where step t falls in this lane's window: k = t - LANE.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    diff     = {1'b0, t} - {1'b0, LANE_T};
    in_row   = ~diff[T_W];
    k        = diff[T_W-1:0];
    k_idx    = k[K_W-1:0];
    word_hit = in_row && (k < DEPTH_T);
    end_hit  = in_row && (k == DEPTH_T);
  end

  // Register this lane's word pair and its end-of-stream flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act  <= '0;
      wgt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (clear) begin
        act  <= '0;
        wgt  <= '0;
        done <= 1'b0;
      end else if (step) begin
        act <= word_hit ? row_act[k_idx] : '0;
        wgt <= word_hit ? row_wgt[k_idx] : '0;
        if (end_hit) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pe_skew_feeder.sv
// Front end of pe_8x8_cluster: buffers one activation tile and one weight
// tile, then on start streams them into the cluster in systolic skew, each
// row lagging the previous by one cycle and ending with a zero word + done.
module pe_skew_feeder
  import pe_skew_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  pe_skew_feeder_if.slave   bus
);

  localparam step_t T_LAST_T = step_t'(T_LAST);

  state_e state;
  step_t  t;
  logic   busy_q;

  word_t  abuf [WORDS];
  word_t  wbuf [WORDS];

  logic   start_go;
  logic   wr_go;
  logic   run;

  // A start or a write only takes effect while enabled and not feeding.
  always_comb begin
    run      = (state == ST_RUN);
    start_go = bus.en && bus.start && !run;
    wr_go    = bus.en && bus.wr_en && !run;
  end

  // Feed sequencer: IDLE/HOLD wait for start, RUN walks t to its last step.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      t      <= '0;
      busy_q <= 1'b0;
    end else if (bus.en) begin
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          if (bus.start) begin
            state  <= ST_RUN;
            t      <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (t == T_LAST_T) begin
            state  <= ST_HOLD;
            busy_q <= 1'b0;
          end else begin
            t <= t + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          t      <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Tile buffers; writes are blocked during a feed so the tile stays stable.
  // NOTE: buffer storage has no reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      if (bus.wr_sel) begin
        wbuf[bus.wr_addr] <= bus.wr_data;
      end else begin
        abuf[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign bus.busy = busy_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    word_t [DEPTH-1:0] row_act;
    word_t [DEPTH-1:0] row_wgt;
    word_t             lane_act;
    word_t             lane_wgt;
    logic              lane_done;

    // Row r of each tile lives at addresses r*DEPTH .. r*DEPTH+DEPTH-1.
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
      assign row_act[k] = abuf[r*DEPTH + k];
      assign row_wgt[k] = wbuf[r*DEPTH + k];
    end

    pe_skew_feeder_lane #(
      .LANE (r)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .clear   (start_go),
      .step    (run),
      .t       (t),
      .row_act (row_act),
      .row_wgt (row_wgt),
      .act     (lane_act),
      .wgt     (lane_wgt),
      .done    (lane_done)
    );

    assign bus.activations[lane_lsb(r) +: DATA_W] = lane_act;
    assign bus.weights[lane_lsb(r) +: DATA_W]     = lane_wgt;
    assign bus.done[r]                            = lane_done;
  end

endmodule
